// File: rtl/mac_operand_feeder.sv
// Operand feeder for mac_unit: buffers signed operand pairs in a small FIFO and
// issues them one at a time over the valid/done handshake, tracking vector ends.
module mac_operand_feeder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             mac_valid,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    input  logic             mac_done,
    output logic             vec_done,
    output logic [CNT_W-1:0] vec_len,
    output logic             busy,
    output logic             proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // state | meaning
    // IDLE  | waiting for a buffered pair; loads head into mac_a/mac_b
    // ISSUE | mac_valid high for this single cycle
    // WAIT  | operands held until mac_done, then head is popped
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state;
    logic [16:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic [16:0]      head;
    logic [CNT_W-1:0] elem_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             full;
    logic             alive;
    logic             push;
    logic             pop;
    logic             busy_nxt;

    // alive keeps in_ready low while reset is held and until the first clock after release
    assign full     = (count == FULL_CNT);
    assign in_ready = alive && !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == WAIT) && mac_done;
    assign head     = mem[rd_ptr];
    assign cnt_inc  = (elem_cnt == '1) ? elem_cnt : elem_cnt + 1'b1;
    assign busy_nxt = (count_nxt != '0) || (state == ISSUE);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_last};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            elem_cnt  <= '0;
            alive     <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
            mac_valid <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            vec_done  <= 1'b0;
            vec_len   <= '0;
        end else begin
            alive     <= 1'b1;
            count     <= count_nxt;
            busy      <= busy_nxt;
            mac_valid <= 1'b0;
            vec_done  <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (mac_done && (state != WAIT)) begin
                proto_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        mac_a     <= head[16:9];
                        mac_b     <= head[8:1];
                        mac_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mac_done) begin
                        state <= IDLE;
                        if (head[0]) begin
                            vec_done <= 1'b1;
                            vec_len  <= cnt_inc;
                            elem_cnt <= '0;
                        end else begin
                            elem_cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench for mac_operand_feeder: stimulus queues expected issues and
// vector lengths, monitors compare them as the DUT presents mac_valid / vec_done.
module tb_mac_operand_feeder;
    logic       clk;
    logic       reset_n;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_a, in_b;
    logic       mac_valid, mac_done;
    logic [7:0] mac_a, mac_b;
    logic       vec_done, busy, proto_err;
    logic [7:0] vec_len;

    logic       in_valid2, in_ready2, in_last2;
    logic [7:0] in_a2, in_b2;
    logic       mac_valid2, mac_done2;
    logic [7:0] mac_a2, mac_b2;
    logic       vec_done2, busy2, proto_err2;
    logic [1:0] vec_len2;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cnt  = 0;
    int mac_lat = 5;
    logic mac_auto = 1'b1;
    int manual_req = 0;
    int manual_ack = 0;

    logic [15:0] exp_issue[$];
    int          exp_vec[$];
    int          exp_vec2[$];

    mac_operand_feeder #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_done(mac_done),
        .vec_done(vec_done), .vec_len(vec_len), .busy(busy), .proto_err(proto_err)
    );

    mac_operand_feeder #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2), .in_last(in_last2),
        .mac_valid(mac_valid2), .mac_a(mac_a2), .mac_b(mac_b2), .mac_done(mac_done2),
        .vec_done(vec_done2), .vec_len(vec_len2), .busy(busy2), .proto_err(proto_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // MAC model for the CNT_W=8 feeder: auto-done after mac_lat cycles, or manual pulses
    initial begin
        int cd;
        cd = 0;
        mac_done = 1'b0;
        forever begin
            @(negedge clk);
            mac_done = 1'b0;
            if (!reset_n) begin
                cd = 0;
            end else begin
                if (manual_req != manual_ack) begin
                    mac_done = 1'b1;
                    manual_ack++;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) mac_done = 1'b1;
                end
                if (mac_valid && mac_auto) cd = mac_lat;
            end
        end
    end

    // MAC model for the CNT_W=2 feeder: fixed one-cycle latency
    initial begin
        int cd2;
        cd2 = 0;
        mac_done2 = 1'b0;
        forever begin
            @(negedge clk);
            mac_done2 = 1'b0;
            if (!reset_n) begin
                cd2 = 0;
            end else begin
                if (cd2 > 0) begin
                    cd2--;
                    if (cd2 == 0) mac_done2 = 1'b1;
                end
                if (mac_valid2) cd2 = 1;
            end
        end
    end

    // Monitor for the main feeder
    initial begin
        logic [15:0] e;
        logic [7:0]  ca, cb;
        logic        holding, prev_done;
        holding = 1'b0;
        prev_done = 1'b0;
        ca = '0;
        cb = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                holding = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (mac_valid) begin
                    if (exp_issue.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_issue: mac_valid with a=%0d b=%0d, none expected",
                                 $signed(mac_a), $signed(mac_b));
                    end else begin
                        e = exp_issue.pop_front();
                        ca = e[15:8];
                        cb = e[7:0];
                        check("issue_a", $signed(mac_a), $signed(ca));
                        check("issue_b", $signed(mac_b), $signed(cb));
                        holding = 1'b1;
                    end
                end else if (holding) begin
                    check("hold_a", $signed(mac_a), $signed(ca));
                    check("hold_b", $signed(mac_b), $signed(cb));
                    if (mac_done) holding = 1'b0;
                end
                if (vec_done) begin
                    if (exp_vec.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_vec_done: vec_len=%0d, none expected", vec_len);
                    end else begin
                        check("vec_len", vec_len, exp_vec.pop_front());
                    end
                    check("vec_done_after_pop", prev_done, 1);
                end
                prev_done = mac_done;
            end
        end
    end

    // Monitor for the saturating (CNT_W=2) feeder
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && vec_done2) begin
                if (exp_vec2.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_vec_done2: vec_len=%0d, none expected", vec_len2);
                end else begin
                    check("vec_len_sat", vec_len2, exp_vec2.pop_front());
                end
            end
        end
    end

    task automatic push(input logic signed [7:0] a, input logic signed [7:0] b, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: in_ready=%0b after 200 cycles, expected 1", in_ready);
        end else begin
            @(posedge clk);
            exp_issue.push_back({a, b});
            tb_cnt = (tb_cnt == 255) ? 255 : tb_cnt + 1;
            if (last) begin
                exp_vec.push_back(tb_cnt);
                tb_cnt = 0;
            end
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic push2(input logic signed [7:0] a, input logic signed [7:0] b, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        in_valid2 = 1'b1;
        in_a2 = a;
        in_b2 = b;
        in_last2 = last;
        while (!in_ready2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL push2_timeout: in_ready=%0b after 200 cycles, expected 1", in_ready2);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid2 = 1'b0;
    endtask

    task automatic pulse_done();
        int t;
        t = 0;
        manual_req++;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (manual_ack != manual_req && t < 10);
        if (manual_ack != manual_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL pulse_done_timeout: ack=%0d, expected %0d", manual_ack, manual_req);
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || busy2) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%0b busy2=%0b, expected 0", name, busy, busy2);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; in_last2 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_mac_valid", mac_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_vec_done", vec_done, 0);
        check("rst_proto_err", proto_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", in_ready, 1);

        // single-element vector, 5-cycle MAC
        mac_lat = 5;
        push(3, -2, 1);
        wait_idle("single");

        // three-element vector, then a fresh vector counts from 1
        mac_lat = 2;
        push(1, 1, 0);
        push(2, -4, 0);
        push(-128, 127, 1);
        push(7, 8, 1);
        wait_idle("three");

        // backpressure: done withheld, fifth pair held until one pop
        mac_auto = 1'b0;
        push(10, -10, 0);
        push(11, -11, 0);
        push(12, -12, 0);
        push(13, -13, 0);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_busy", busy, 1);
        fork
            push(14, -14, 1);
            begin
                repeat (3) @(negedge clk);
                check("held_in_ready", in_ready, 0);
                pulse_done();
                mac_auto = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("ready_after_pop", in_ready, 1);
            end
        join
        wait_idle("backpressure");

        // mac_done in IDLE: sticky error, count and occupancy untouched
        push(20, 21, 0);
        wait_idle("proto_pre");
        check("proto_err_clean", proto_err, 0);
        pulse_done();
        @(negedge clk);
        check("proto_err_set", proto_err, 1);
        check("proto_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("proto_err_sticky", proto_err, 1);
        push(22, 23, 1);
        wait_idle("proto_post");

        // saturating counter on CNT_W=2 instance
        exp_vec2.push_back(3);
        push2(1, 2, 0);
        push2(3, 4, 0);
        push2(5, 6, 0);
        push2(7, 8, 0);
        push2(-9, 10, 1);
        wait_idle("sat");
        check("sat_keep_a", $signed(mac_a2), -9);
        check("sat_keep_b", $signed(mac_b2), 10);
        check("sat_proto_err", proto_err2, 0);

        // reset in the middle of WAIT
        mac_auto = 1'b0;
        push(5, 6, 0);
        repeat (4) @(negedge clk);
        check("wait_mac_a", mac_a, 5);
        check("wait_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        exp_issue.delete();
        exp_vec.delete();
        tb_cnt = 0;
        check("abort_mac_a", mac_a, 0);
        check("abort_mac_b", mac_b, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_proto_err", proto_err, 0);
        check("abort_vec_len", vec_len, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mac_auto = 1'b1;
        @(negedge clk);
        check("abort_ready_after", in_ready, 1);
        check("abort_busy_after", busy, 0);
        repeat (6) @(negedge clk);
        check("abort_no_issue", mac_valid, 0);

        check("issue_queue_empty", exp_issue.size(), 0);
        check("vec_queue_empty", exp_vec.size(), 0);
        check("vec2_queue_empty", exp_vec2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
